float2int_serial: RTL and testbench
===================================

// Module: float2int_serial
// PURPOSE
//  Serial decoder from the 7-bit {E[2:0],M[3:0]} mini-float to an 11-bit unsigned integer.
//  It is the inverse of the team's int2float encoder.
//  Encoding: E==0 -> value = M; E==k (1..7) -> value = {1'b1,M} << (k-1); range 0..1984.
//  It uses an iterative shifter, one bit per cycle, with valid/ready on both sides.
//  It sits between float-compressed storage and integer datapaths in ALS benchmark harnesses.
// PARAMETERS
//  MW        4   mantissa width (fraction bits, hidden 1 above them when E!=0)
//  EW        3   exponent width
//  IW        11  integer output width; must equal MW+1+(2**EW-2)
//  FILL_MID  0   0: low end of bucket; 1: add midpoint 1<<(k-2) when E>=2
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   input word present
//  in_ready   out  1   block accepts {E,M} this cycle
//  E          in   EW  exponent
//  M          in   MW  mantissa
//  out_valid  out  1   B valid, held until out_ready
//  out_ready  in   1   consumer accepts B
//  B          out  IW  decoded integer
//  busy       out  1   high in SHIFT state
// BEHAVIOUR
//  Clock and reset:
//  - One clock, clk. rst_n is asynchronous and active-low.
//  - Reset: state=IDLE, B=0, out_valid=0, busy=0, shift counter=0, in_ready=1 on the next cycle after release.
//  States: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1. On in_valid:
//    - E==0: B<=zero-extended M, go to DONE.
//    - E!=0: acc<={1,M}, cnt<=E-1; go to SHIFT if cnt!=0, else to DONE with B<=acc.
//  - SHIFT: acc<=acc<<1, cnt<=cnt-1 each cycle. When cnt reaches 1, load B with the final shift value (plus the midpoint if FILL_MID and E>=2) and go to DONE.
//  - DONE: out_valid=1; B and out_valid stay stable while out_ready=0.
//    - On out_ready, with in_valid=0: go to IDLE.
//    - On out_ready with in_valid (in_ready=1 in DONE only when out_ready=1): accept the new word in the same cycle, with the same IDLE decode rules. No bubble.
//  Latency, counted from the accept edge to out_valid high:
//  - 1 cycle for E<=1.
//  - E cycles for E>=2, max 7.
//  - Throughput is one word per max(1,E) cycles when out_ready stays high.
//  Width rules:
//  - acc is IW bits. The shift never overflows because the top bit reaches at most bit IW-1 at E=7.
//  - The midpoint adds into zero bits only, so there is no carry.
//  Boundary cases:
//  - in_valid dropped while not in_ready: ignored, with no state change.
//  - E,M change while SHIFT: ignored; the operands are latched at accept.
//  - rst_n asserted mid-SHIFT: immediate return to reset values, and the in-flight word is discarded.
//  - out_ready high while out_valid=0: no effect.
//  - {E,M}=0: B=0 with 1-cycle latency, not treated as a special case.
// STRUCTURE
//  - Package float2int_pkg holds:
//    - localparams MW, EW, IW, and the derived CNTW=$clog2(2**EW).
//    - typedef enum logic [1:0] {IDLE,SHIFT,DONE} f2i_state_t.
//    - function f2i_ref(E,M), the golden combinational decode, shared with the bench.
//  - One sub-module, f2i_shift_dp: holds acc, cnt, the midpoint injection and the B register, with a load/step/commit interface.
//  - The FSM and handshake stay in float2int_serial.
// TESTING
//  1. Reset with in_valid=1, E=5, M=4'hA asserted mid-stream -> B=0, out_valid=0; in_ready=1 on the first cycle after release.
//  2. E=0, M=4'h9, out_ready=1 -> out_valid 1 cycle later with B=11'd9; E=1, M=4'h0 -> B=11'd16, latency 1.
//  3. E=7, M=4'hF, FILL_MID=0 -> B=11'd1984 after 7 cycles, busy high for 6 cycles. With FILL_MID=1 -> B=11'd2016.
//  4. Backpressure: E=3, M=4'h2 (B=72), out_ready=0 for 10 cycles -> B and out_valid stable, in_ready=0.
//     Then out_ready=1 with in_valid=1, E=0, M=4'h3 -> back-to-back accept, next B=3 one cycle later.
//  5. Assert rst_n low at cycle 3 of E=6 SHIFT -> all outputs back to reset values asynchronously; no stale out_valid after release.
//  6. Exhaustive: all 128 {E,M}, random out_ready/in_valid -> every B equals f2i_ref(E,M); ordering preserved; no drops or duplicates.
//     Also run int2float(B) round-trip: f2i(int2float(B)) <= B for all 2048 B.

Source files
------------

// File: rtl/float2int_pkg.sv
// float2int_pkg
// Shared definitions for the serial mini-float to integer decoder.
//   MW   : mantissa (fraction) width
//   EW   : exponent width
//   IW   : decoded integer width, MW+1+(2**EW-2)
//   CNTW : shift counter width
//   f2i_state_t : controller states IDLE / SHIFT / DONE
//   f2i_ref()   : golden combinational decode of one {E,M} word
package float2int_pkg;

  localparam int MW   = 4;
  localparam int EW   = 3;
  localparam int IW   = MW + 1 + (2**EW - 2);
  localparam int CNTW = $clog2(2**EW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } f2i_state_t;

  // E==0 is the denormal range (value = M). Otherwise the hidden 1 sits
  // above M and the whole mantissa is scaled by 2**(E-1). With fill_mid the
  // result moves from the bottom of the bucket to its midpoint; that bit
  // always lands in the zero bits vacated by the shift, so OR equals ADD.
  function automatic logic [IW-1:0] f2i_ref(input logic [EW-1:0] e,
                                            input logic [MW-1:0] m,
                                            input logic          fill_mid = 1'b0);
    logic [IW-1:0] v;
    v = '0;
    if (e == '0) begin
      v = {{(IW-MW){1'b0}}, m};
    end else begin
      v = {{(IW-MW-1){1'b0}}, 1'b1, m} << (e - EW'(1));
      if (fill_mid && (e >= EW'(2))) begin
        v = v | (IW'(1) << (e - EW'(2)));
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/f2i_shift_dp.sv
// f2i_shift_dp
// Datapath of the serial decoder: accumulator, shift counter, latched
// exponent (for the midpoint), and the output register B.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture a new {E,M} word (acc, cnt, exponent)
//   i_e, i_m   : exponent / mantissa of the word being loaded
//   i_step     : shift acc left by one and decrement cnt
//   i_commit   : write B; from the load value when i_load is high,
//                otherwise from the final shift (plus midpoint)
//   o_last     : cnt==1, the current step is the final one
//   o_b        : decoded integer register
module f2i_shift_dp
  import float2int_pkg::*;
#(
  parameter int FILL_MID = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [EW-1:0] i_e,
  input  logic [MW-1:0] i_m,
  input  logic          i_step,
  input  logic          i_commit,
  output logic          o_last,
  output logic [IW-1:0] o_b
);

  logic [IW-1:0]   r_acc;
  logic [IW-1:0]   r_b;
  logic [CNTW-1:0] r_cnt;
  logic [EW-1:0]   r_e;

  logic [IW-1:0]   w_load_val;
  logic [IW-1:0]   w_shift_val;
  logic [IW-1:0]   w_mid;
  logic [IW-1:0]   w_final;
  logic [CNTW-1:0] w_load_cnt;

  always_comb begin
    w_load_val  = '0;
    w_load_cnt  = '0;
    w_shift_val = r_acc << 1;
    w_mid       = '0;
    if (i_e == '0) begin
      w_load_val = {{(IW-MW){1'b0}}, i_m};
    end else begin
      w_load_val = {{(IW-MW-1){1'b0}}, 1'b1, i_m};
      w_load_cnt = CNTW'(i_e - EW'(1));
    end
    // Midpoint bit sits just below the lowest bit the shift can set.
    if ((FILL_MID != 0) && (r_e >= EW'(2))) begin
      w_mid = IW'(1) << (r_e - EW'(2));
    end
    w_final = w_shift_val | w_mid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_e   <= '0;
      r_b   <= '0;
    end else begin
      if (i_load) begin
        r_acc <= w_load_val;
        r_cnt <= w_load_cnt;
        r_e   <= i_e;
      end else if (i_step) begin
        r_acc <= w_shift_val;
        r_cnt <= r_cnt - CNTW'(1);
      end
      if (i_commit) begin
        r_b <= i_load ? w_load_val : w_final;
      end
    end
  end

  assign o_last = (r_cnt == CNTW'(1));
  assign o_b    = r_b;

endmodule

// File: rtl/float2int_serial.sv
// float2int_serial
// Serial decoder from the 7-bit {E,M} mini-float to an 11-bit unsigned
// integer, shifting one bit per cycle. Inverse of the int2float encoder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : input word present
//   in_ready     : decoder takes {E,M} this cycle
//   E, M         : exponent / mantissa
//   out_valid    : B valid, held until out_ready
//   out_ready    : consumer takes B
//   B            : decoded integer
//   busy         : high while in SHIFT
//   o_dbg_state  : current controller state (f2i_state_t encoding)
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Once out_valid is raised, B and out_valid stay
// unchanged until that transfer. in_ready never depends on in_valid; in
// DONE it follows out_ready, so a new word can replace the outgoing result
// on the same edge with no bubble.
module float2int_serial
  import float2int_pkg::*;
#(
  parameter int FILL_MID = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] E,
  input  logic [MW-1:0] M,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] B,
  output logic          busy,
  output logic [1:0]    o_dbg_state
);

  f2i_state_t r_state;
  f2i_state_t w_next;

  logic w_in_ready;
  logic w_out_valid;
  logic w_busy;
  logic w_load;
  logic w_step;
  logic w_commit;
  logic w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
      end
      SHIFT: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_commit = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Accept path shared by IDLE and DONE. E<=1 needs no shifting, so B
    // is written straight from the load value.
    if (in_valid && w_in_ready) begin
      w_load = 1'b1;
      if (E <= EW'(1)) begin
        w_commit = 1'b1;
        w_next   = DONE;
      end else begin
        w_next = SHIFT;
      end
    end
  end

  f2i_shift_dp #(
    .FILL_MID (FILL_MID)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_e      (E),
    .i_m      (M),
    .i_step   (w_step),
    .i_commit (w_commit),
    .o_last   (w_last),
    .o_b      (B)
  );

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign busy        = w_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_float2int_serial.sv
// tb_float2int_serial
// Bench for float2int_serial. Two instances share all inputs: one with
// FILL_MID=0 and one with FILL_MID=1. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_float2int_serial;
  import float2int_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [EW-1:0] E = '0;
  logic [MW-1:0] M = '0;

  logic          in_ready, out_valid, busy;
  logic [IW-1:0] B;
  logic [1:0]    dbg;
  logic          in_ready_m, out_valid_m, busy_m;
  logic [IW-1:0] B_m;
  logic [1:0]    dbg_m;

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] exp_m_q[$];

  float2int_serial #(.FILL_MID(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .E(E), .M(M), .out_valid(out_valid), .out_ready(out_ready), .B(B),
    .busy(busy), .o_dbg_state(dbg)
  );

  float2int_serial #(.FILL_MID(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .E(E), .M(M), .out_valid(out_valid_m), .out_ready(out_ready), .B(B_m),
    .busy(busy_m), .o_dbg_state(dbg_m)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Independent decode model written from the encoding definition.
  function automatic logic [IW-1:0] model(input int e, input int m, input bit fm);
    int v;
    if (e == 0) begin
      v = m;
    end else begin
      v = (16 + m) << (e - 1);
      if (fm && e >= 2) v = v + (1 << (e - 2));
    end
    return IW'(v);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int e, input int m);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    E = EW'(e);
    M = MW'(m);
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    check("send_accept", 32'(rdy), 1);
    in_valid = 1'b0;
  endtask

  // Called at +1 after the accept edge; returns on the falling edge where
  // out_valid is first seen high (or the budget runs out).
  task automatic measure(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1000000;
    check("watchdog", 1, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int lat, bc, stable, any_bad, idx, n_out, n_out_m, cyc, rt_bad;
    logic acc;

    // 1. reset, then reset again mid-SHIFT with in_valid held high
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; E = 3'd5; M = 4'hA;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_b", B, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg, 32'(IDLE));
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // 2. E<=1 words, one-cycle latency
    tick();
    out_ready = 1'b1;
    send(0, 9);
    measure(lat, bc);
    check("e0_lat", lat, 1);
    check("e0_b", B, 9);
    tick();
    send(1, 0);
    measure(lat, bc);
    check("e1_lat", lat, 1);
    check("e1_b", B, 16);
    check("e1_bm", B_m, 16);
    tick();

    // 3. longest shift and a two-cycle shift
    send(7, 15);
    measure(lat, bc);
    check("e7_lat", lat, 7);
    check("e7_busy", bc, 6);
    check("e7_b", B, 1984);
    check("e7_bm", B_m, 2016);
    tick();
    send(2, 0);
    measure(lat, bc);
    check("e2_lat", lat, 2);
    check("e2_b", B, 32);
    check("e2_bm", B_m, 33);
    tick();

    // 4. backpressure then back-to-back accept
    out_ready = 1'b0;
    send(3, 2);
    measure(lat, bc);
    check("e3_lat", lat, 3);
    check("e3_b", B, 72);
    check("e3_bm", B_m, 74);
    in_valid = 1'b1; E = 3'd0; M = 4'h3;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (!(B == 72 && B_m == 74 && out_valid && !in_ready)) stable = 0;
    end
    check("bp_stable", stable, 1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_out_valid", out_valid, 1);
    check("b2b_b", B, 3);
    tick();

    // 5. asynchronous reset during the third SHIFT cycle of E=6
    send(6, 5);
    tick();
    tick();
    check("e6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_b", B, 0);
    check("arst_bm", B_m, 0);
    check("arst_state", dbg, 32'(IDLE));
    tick();
    rst_n = 1'b1;
    any_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || out_valid_m || busy) any_bad = 1;
    end
    check("arst_no_stale", any_bad, 0);
    tick();

    // 6. all 128 words with random valid/ready
    idx = 0; n_out = 0; n_out_m = 0; cyc = 0;
    while ((idx < 128 || n_out < 128 || n_out_m < 128) && cyc < 20000) begin
      if (!in_valid && idx < 128 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        E = EW'(idx >> 4);
        M = MW'(idx & 15);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("ex_spurious", 1, 0);
        else check("ex_b", B, exp_q.pop_front());
        n_out++;
      end
      if (out_valid_m && out_ready) begin
        if (exp_m_q.size() == 0) check("ex_spurious_m", 1, 0);
        else check("ex_bm", B_m, exp_m_q.pop_front());
        n_out_m++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(idx >> 4, idx & 15, 1'b0));
        exp_m_q.push_back(model(idx >> 4, idx & 15, 1'b1));
        idx++;
      end
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    check("ex_count", n_out, 128);
    check("ex_count_m", n_out_m, 128);
    check("ex_q_empty", exp_q.size(), 0);

    // Package golden decode against the independent model.
    any_bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (f2i_ref(EW'(i >> 4), MW'(i & 15), 1'b0) != model(i >> 4, i & 15, 1'b0)) any_bad++;
      if (f2i_ref(EW'(i >> 4), MW'(i & 15), 1'b1) != model(i >> 4, i & 15, 1'b1)) any_bad++;
    end
    check("ref_vs_model", any_bad, 0);

    // Round trip: encode every integer (truncating), decode, never exceed it.
    rt_bad = 0;
    for (int b = 0; b < 2048; b++) begin
      int p;
      logic [EW-1:0] e;
      logic [MW-1:0] m;
      if (b < 16) begin
        e = '0;
        m = MW'(b);
      end else begin
        p = 0;
        for (int k = 0; k < 11; k++) if (((b >> k) & 1) != 0) p = k;
        e = EW'(p - 3);
        m = MW'(b >> (p - 4));
      end
      if (int'(f2i_ref(e, m, 1'b0)) > b) rt_bad++;
    end
    check("round_trip", rt_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
